// File: rtl/rv_pkg.sv
// Shared RV32 writeback definitions: source selects, load funct3 codes and the
// load-data extraction helper used by the writeback stage.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unknown funct3 codes pass the raw word; they never reach here legally.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [2:0]      funct3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_res;
    w_byte = 8'(word >> {off, 3'b000});
    w_half = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   w_res = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_res = {24'd0, w_byte};
      F3_LH:   w_res = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_res = {16'd0, w_half};
      F3_LW:   w_res = word;
      default: w_res = word;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one synchronous write port, two
// combinational read ports with x0 masking and same-cycle write bypass.
module regfile_2r1w
  import rv_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [DW-1:0]            rdata1,
  output logic [DW-1:0]            rdata2
);

  localparam int AW = $clog2(NREGS);

  logic [DW-1:0] r_regs [NREGS];

  // Storage update; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && (waddr != AW'(0))) begin
      r_regs[waddr] <= wdata;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Read port 1: x0 reads zero, a matching write this cycle is forwarded.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == AW'(0)) begin
      rdata1 = '0;
    end else if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = r_regs[raddr1];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2 = '0;
    if (raddr2 == AW'(0)) begin
      rdata2 = '0;
    end else if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = r_regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU / load / PC+4 result, commits it to the
// register file and counts retired instructions.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic             wb_rdEn,
  input  logic [4:0]       wb_rd,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       wb_funct3,
  input  logic [1:0]       wb_addr_lo,
  input  logic [XLEN-1:0]  alu_out_p,
  input  logic [XLEN-1:0]  dmem_out_p,
  input  logic [XLEN-1:0]  pc4_p,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  w_load;
  logic [CNT_W-1:0] r_instret;

  assign w_load = load_extract(wb_funct3, wb_addr_lo, dmem_out_p);

  // rst_n gates the strobe so a write coinciding with reset is not reported.
  assign wb_we = rst_n & wb_valid & wb_rdEn & (wb_rd != 5'd0);

  // Writeback source mux; code 11 aliases the ALU path.
  always_comb begin
    wb_data = alu_out_p;
    case (wb_sel)
      WB_SEL_ALU: wb_data = alu_out_p;
      WB_SEL_MEM: wb_data = w_load;
      WB_SEL_PC4: wb_data = pc4_p;
      default:    wb_data = alu_out_p;
    endcase
  end

  // Retired-instruction counter, wraps naturally at full width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (wb_valid) begin
      r_instret <= r_instret + CNT_W'(1);
    end else begin
      r_instret <= r_instret;
    end
  end

  assign instret = r_instret;

  regfile_2r1w #(
    .DW    (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver queues hand-computed expectations
// tagged with their cycle; a monitor on the falling edge pops and compares.
module tb_wb_regfile;

  localparam int SIG_RS1 = 0;
  localparam int SIG_RS2 = 1;
  localparam int SIG_WBD = 2;
  localparam int SIG_WE  = 3;
  localparam int SIG_CNT = 4;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_rdEn;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;
  logic [31:0] alu_out_p;
  logic [31:0] dmem_out_p;
  logic [31:0] pc4_p;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [63:0] instret;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] mon_act;
  int          cyc;
  int          n_vec;
  int          n_bad;

  wb_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rdEn    (wb_rdEn),
    .wb_rd      (wb_rd),
    .wb_sel     (wb_sel),
    .wb_funct3  (wb_funct3),
    .wb_addr_lo (wb_addr_lo),
    .alu_out_p  (alu_out_p),
    .dmem_out_p (dmem_out_p),
    .pc4_p      (pc4_p),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sig)
        SIG_RS1: mon_act = {32'd0, rs1_data};
        SIG_RS2: mon_act = {32'd0, rs2_data};
        SIG_WBD: mon_act = {32'd0, wb_data};
        SIG_WE:  mon_act = {63'd0, wb_we};
        default: mon_act = instret;
      endcase
      n_vec++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                 mon_e.name, mon_act, mon_e.val, cyc, mon_e.cyc);
      end
    end
  end

  task automatic expect_now(input int sig, input logic [63:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    wb_rdEn  = 1'b0;
    wb_rd    = 5'd0;
    wb_sel   = 2'b00;
  endtask

  task automatic issue(input logic v, input logic en, input logic [4:0] rd,
                       input logic [1:0] sel);
    wb_valid = v;
    wb_rdEn  = en;
    wb_rd    = rd;
    wb_sel   = sel;
  endtask

  task automatic load_chk(input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] exp_v, input string name);
    issue(1'b0, 1'b0, 5'd0, 2'b01);
    wb_funct3  = f3;
    wb_addr_lo = off;
    expect_now(SIG_WBD, {32'd0, exp_v}, name);
    step();
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    wb_funct3  = 3'b000;
    wb_addr_lo = 2'b00;
    alu_out_p  = 32'd0;
    dmem_out_p = 32'd0;
    pc4_p      = 32'd0;
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
    idle();

    step();
    step();
    rst_n = 1'b1;

    n_vec++;
    if (instret !== 64'd0) begin
        n_bad++;
        $display("FAIL direct_reset_instret: got %h expected 0", instret);
    end

    // Reset state: every register and the counter read zero.
    expect_now(SIG_CNT, 64'd0, "reset_instret");
    for (int i = 1; i < 32; i += 2) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i + 1);
      expect_now(SIG_RS1, 64'd0, "reset_rs1");
      expect_now(SIG_RS2, 64'd0, "reset_rs2");
      step();
    end

    // ALU write to x5 with same-cycle bypass on both ports.
    issue(1'b1, 1'b1, 5'd5, 2'b00);
    alu_out_p = 32'hDEADBEEF;
    rs1_addr  = 5'd5;
    rs2_addr  = 5'd5;
    expect_now(SIG_WE,  64'd1, "alu_we");
    expect_now(SIG_WBD, 64'h0000_0000_DEAD_BEEF, "alu_wbdata");
    expect_now(SIG_RS1, 64'h0000_0000_DEAD_BEEF, "bypass_rs1");
    expect_now(SIG_RS2, 64'h0000_0000_DEAD_BEEF, "bypass_rs2");
    expect_now(SIG_CNT, 64'd0, "instret_before_retire");
    step();
    n_vec++;
    if (dut.u_rf.r_regs[5] !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL direct_x5_stored: got %h expected deadbeef", dut.u_rf.r_regs[5]);
    end
    idle();
    rs2_addr = 5'd6;
    expect_now(SIG_RS1, 64'h0000_0000_DEAD_BEEF, "x5_next_cycle");
    expect_now(SIG_RS2, 64'd0, "x6_untouched");
    expect_now(SIG_CNT, 64'd1, "instret_1");
    expect_now(SIG_WE,  64'd0, "idle_we");
    step();

    // Valid write to x0 is dropped but still retires.
    issue(1'b1, 1'b1, 5'd0, 2'b00);
    alu_out_p = 32'h12345678;
    rs1_addr  = 5'd0;
    rs2_addr  = 5'd0;
    expect_now(SIG_WE,  64'd0, "x0_we");
    expect_now(SIG_RS2, 64'd0, "x0_rs2");
    expect_now(SIG_RS1, 64'd0, "x0_rs1");
    step();
    issue(1'b0, 1'b1, 5'd0, 2'b00);
    expect_now(SIG_WE,  64'd0, "invalid_we");
    expect_now(SIG_CNT, 64'd2, "instret_x0_retired");
    step();
    // Invalid slot writing a real register: no write, no retire.
    issue(1'b0, 1'b1, 5'd9, 2'b00);
    rs1_addr = 5'd9;
    expect_now(SIG_WE,  64'd0, "invalid_rd9_we");
    expect_now(SIG_RS1, 64'd0, "invalid_no_bypass");
    expect_now(SIG_CNT, 64'd2, "instret_invalid_hold");
    step();
    idle();
    expect_now(SIG_RS1, 64'd0, "invalid_no_write");
    expect_now(SIG_CNT, 64'd2, "instret_still_2");
    step();

    // Load extraction from 0x80FF7F01.
    dmem_out_p = 32'h80FF7F01;
    load_chk(3'b000, 2'd3, 32'hFFFFFF80, "lb_off3");
    load_chk(3'b100, 2'd1, 32'h0000007F, "lbu_off1");
    load_chk(3'b001, 2'd2, 32'hFFFF80FF, "lh_off2");
    load_chk(3'b101, 2'd0, 32'h00007F01, "lhu_off0");
    load_chk(3'b010, 2'd0, 32'h80FF7F01, "lw_off0");
    load_chk(3'b001, 2'd3, 32'hFFFF80FF, "lh_off3_ignore_lsb");
    load_chk(3'b000, 2'd2, 32'hFFFFFFFF, "lb_off2");
    load_chk(3'b100, 2'd0, 32'h00000001, "lbu_off0");
    load_chk(3'b000, 2'd0, 32'h00000001, "lb_off0_pos");
    load_chk(3'b101, 2'd2, 32'h000080FF, "lhu_off2");
    load_chk(3'b011, 2'd1, 32'h80FF7F01, "f3_011_raw");
    load_chk(3'b110, 2'd2, 32'h80FF7F01, "f3_110_raw");

    // Committed load into x10.
    issue(1'b1, 1'b1, 5'd10, 2'b01);
    wb_funct3  = 3'b100;
    wb_addr_lo = 2'd1;
    step();
    idle();
    rs2_addr = 5'd10;
    expect_now(SIG_RS2, 64'h0000_0000_0000_007F, "x10_load");
    expect_now(SIG_CNT, 64'd3, "instret_3");
    step();

    // JAL writeback of PC+4 into x1, while x5 is read unbypassed.
    issue(1'b1, 1'b1, 5'd1, 2'b10);
    pc4_p     = 32'h00000104;
    alu_out_p = 32'hAAAA5555;
    rs1_addr  = 5'd5;
    expect_now(SIG_WBD, 64'h0000_0000_0000_0104, "jal_wbdata");
    expect_now(SIG_RS1, 64'h0000_0000_DEAD_BEEF, "x5_during_jal");
    step();
    n_vec++;
    if (dut.u_rf.r_regs[1] !== 32'h00000104) begin
        n_bad++;
        $display("FAIL direct_x1_jal: got %h expected 00000104", dut.u_rf.r_regs[1]);
    end
    issue(1'b0, 1'b0, 5'd0, 2'b11);
    rs1_addr = 5'd1;
    expect_now(SIG_RS1, 64'h0000_0000_0000_0104, "x1_jal");
    expect_now(SIG_WBD, 64'h0000_0000_AAAA_5555, "sel11_alu");
    expect_now(SIG_CNT, 64'd4, "instret_4");
    step();

    // Counter wrap from all ones.
    idle();
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    wb_valid = 1'b1;
    expect_now(SIG_CNT, 64'hFFFF_FFFF_FFFF_FFFF, "instret_max");
    step();
    n_vec++;
    if (instret !== 64'd0) begin
        n_bad++;
        $display("FAIL direct_instret_wrap: got %h expected 0", instret);
    end
    idle();
    expect_now(SIG_CNT, 64'd0, "instret_wrap");
    step();

    // Reset coinciding with a write to x7: reset wins.
    rst_n = 1'b0;
    issue(1'b1, 1'b1, 5'd7, 2'b00);
    alu_out_p = 32'h00000077;
    rs1_addr  = 5'd7;
    expect_now(SIG_WE,  64'd0, "rst_we");
    expect_now(SIG_RS1, 64'd0, "rst_no_bypass");
    step();
    n_vec++;
    if (dut.u_rf.r_regs[7] !== 32'd0) begin
        n_bad++;
        $display("FAIL direct_x7_reset: got %h expected 0", dut.u_rf.r_regs[7]);
    end
    rst_n = 1'b1;
    idle();
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    expect_now(SIG_RS1, 64'd0, "x7_after_rst");
    expect_now(SIG_RS2, 64'd0, "x5_cleared");
    expect_now(SIG_CNT, 64'd0, "instret_after_rst");
    step();

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      step();
    end
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: got no sample expected %h", mon_e.name, mon_e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
